// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder/subtractor: WIDTH bits split into STAGES chunks,
// one chunk added per register stage, carry registered between stages.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] augend,
    input  logic [WIDTH-1:0] addend,
    input  logic             carry_in,
    input  logic             subtract,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);

    // Guarded divisor keeps elaboration of a bad STAGES from dividing by zero
    // before the parameter check below reports it.
    localparam int SAFE_STAGES = (STAGES >= 1) ? STAGES : 1;
    localparam int CW          = WIDTH / SAFE_STAGES;

    if (STAGES < 1 || STAGES > WIDTH || (WIDTH % SAFE_STAGES) != 0) begin : g_bad_params
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and 1 <= STAGES <= WIDTH");
    end

    // Handshake: a beat moves on a side when valid && ready on that side.
    // The whole pipe advances as one unit when the output slot is empty or
    // being drained; in_ready is that advance signal and never looks at in_valid.
    logic advance;

    logic             v_q [STAGES];
    logic             v_d [STAGES];
    logic             c_q [STAGES];
    logic             c_d [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic [WIDTH-1:0] s_d [STAGES];
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] a_d [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] b_d [STAGES];
    logic             m_q;
    logic             m_d;

    logic [WIDTH-1:0] b_in;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] s_prev;
    logic             cin;
    logic             v_prev;
    logic [CW:0]      chunk;

    assign advance = !v_q[STAGES-1] || out_ready;
    assign b_in    = subtract ? ~addend : addend;

    always_comb begin
        op_a   = '0;
        op_b   = '0;
        s_prev = '0;
        cin    = 1'b0;
        v_prev = 1'b0;
        chunk  = '0;
        m_d    = m_q;
        for (int k = 0; k < STAGES; k++) begin
            v_d[k] = v_q[k];
            c_d[k] = c_q[k];
            s_d[k] = s_q[k];
            a_d[k] = a_q[k];
            b_d[k] = b_q[k];
        end
        if (advance) begin
            for (int k = 0; k < STAGES; k++) begin
                if (k == 0) begin
                    op_a   = augend;
                    op_b   = b_in;
                    cin    = carry_in;
                    s_prev = '0;
                    v_prev = in_valid;
                end else begin
                    op_a   = a_q[k-1];
                    op_b   = b_q[k-1];
                    cin    = c_q[k-1];
                    s_prev = s_q[k-1];
                    v_prev = v_q[k-1];
                end
                chunk = {1'b0, op_a[k*CW +: CW]} + {1'b0, op_b[k*CW +: CW]}
                      + {{CW{1'b0}}, cin};
                v_d[k] = v_prev;
                c_d[k] = chunk[CW];
                a_d[k] = op_a;
                b_d[k] = op_b;
                s_d[k] = s_prev;
                s_d[k][k*CW +: CW] = chunk[CW-1:0];
                // Carry into the MSB recovered from the MSB sum bit: s = a ^ b ^ c.
                if (k == STAGES - 1) begin
                    m_d = op_a[WIDTH-1] ^ op_b[WIDTH-1] ^ chunk[CW-1];
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                s_q[k] <= '0;
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
            m_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= v_d[k];
                c_q[k] <= c_d[k];
                s_q[k] <= s_d[k];
                a_q[k] <= a_d[k];
                b_q[k] <= b_d[k];
            end
            m_q <= m_d;
        end
    end

    assign in_ready  = advance;
    assign out_valid = v_q[STAGES-1];
    assign sum       = s_q[STAGES-1];
    assign carry_out = c_q[STAGES-1];
    assign overflow  = m_q ^ c_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench: 8-bit/2-stage instance for arithmetic, stall and reset cases,
// plus 32-bit instances with 1, 4 and 32 stages fed one shared vector stream.
module tb_pipelined_adder;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  // 8-bit, 2-stage instance
  logic       in_valid8 = 1'b0;
  logic       in_ready8;
  logic [7:0] augend8 = '0;
  logic [7:0] addend8 = '0;
  logic       carry_in8 = 1'b0;
  logic       subtract8 = 1'b0;
  logic       out_valid8;
  logic       out_ready8 = 1'b1;
  logic [7:0] sum8;
  logic       carry_out8;
  logic       overflow8;

  pipelined_adder #(.WIDTH(8), .STAGES(2)) dut8 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid8), .in_ready(in_ready8),
    .augend(augend8), .addend(addend8),
    .carry_in(carry_in8), .subtract(subtract8),
    .out_valid(out_valid8), .out_ready(out_ready8),
    .sum(sum8), .carry_out(carry_out8), .overflow(overflow8)
  );

  // 32-bit instances share inputs
  logic        in_valid32 = 1'b0;
  logic [31:0] augend32 = '0;
  logic [31:0] addend32 = '0;
  logic        carry_in32 = 1'b0;
  logic        subtract32 = 1'b0;
  logic        out_ready32 = 1'b1;

  logic        in_ready_s1, in_ready_s4, in_ready_s32;
  logic        out_valid_s1, out_valid_s4, out_valid_s32;
  logic [31:0] sum_s1, sum_s4, sum_s32;
  logic        co_s1, co_s4, co_s32;
  logic        ov_s1, ov_s4, ov_s32;

  pipelined_adder #(.WIDTH(32), .STAGES(1)) dut_s1 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid32), .in_ready(in_ready_s1),
    .augend(augend32), .addend(addend32),
    .carry_in(carry_in32), .subtract(subtract32),
    .out_valid(out_valid_s1), .out_ready(out_ready32),
    .sum(sum_s1), .carry_out(co_s1), .overflow(ov_s1)
  );

  pipelined_adder #(.WIDTH(32), .STAGES(4)) dut_s4 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid32), .in_ready(in_ready_s4),
    .augend(augend32), .addend(addend32),
    .carry_in(carry_in32), .subtract(subtract32),
    .out_valid(out_valid_s4), .out_ready(out_ready32),
    .sum(sum_s4), .carry_out(co_s4), .overflow(ov_s4)
  );

  pipelined_adder #(.WIDTH(32), .STAGES(32)) dut_s32 (
    .clock(clock), .reset(reset),
    .in_valid(in_valid32), .in_ready(in_ready_s32),
    .augend(augend32), .addend(addend32),
    .carry_in(carry_in32), .subtract(subtract32),
    .out_valid(out_valid_s32), .out_ready(out_ready32),
    .sum(sum_s32), .carry_out(co_s32), .overflow(ov_s32)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];

  // 32-bit vectors; expected packed as {carry_out, overflow, sum}
  localparam int NV = 8;
  logic [31:0] va   [NV] = '{32'hFFFFFFFF, 32'h7FFFFFFF, 32'h12345678, 32'h00000000,
                             32'h80000000, 32'h0000FFFF, 32'h00000010, 32'h80000000};
  logic [31:0] vb   [NV] = '{32'h00000001, 32'h00000001, 32'h87654321, 32'h00000001,
                             32'h00000001, 32'h00000000, 32'h00000005, 32'h80000000};
  logic        vci  [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic        vsub [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
  logic [33:0] vexp [NV] = '{{2'b10, 32'h00000000}, {2'b01, 32'h80000000},
                             {2'b00, 32'h99999999}, {2'b00, 32'hFFFFFFFF},
                             {2'b11, 32'h7FFFFFFF}, {2'b00, 32'h00010000},
                             {2'b10, 32'h0000000A}, {2'b11, 32'h00000000}};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One isolated beat through the 2-stage instance: checks acceptance,
  // that nothing shows early, and the result exactly two edges later.
  task automatic do_op8(input string tag, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic sub,
                        input logic [7:0] es, input logic ec, input logic eo);
    @(negedge clock);
    augend8 = a; addend8 = b; carry_in8 = ci; subtract8 = sub; in_valid8 = 1'b1;
    #1 check({tag, "_in_ready"}, in_ready8, 1);
    @(negedge clock);
    in_valid8 = 1'b0;
    check({tag, "_early_valid"}, out_valid8, 0);
    @(negedge clock);
    check({tag, "_out_valid"}, out_valid8, 1);
    check({tag, "_sum"}, sum8, es);
    check({tag, "_carry_out"}, carry_out8, ec);
    check({tag, "_overflow"}, overflow8, eo);
  endtask

  task automatic mon32(input string tag, input logic vld, input logic [33:0] res,
                       input int t, input int stages, inout int idx);
    if (vld) begin
      if (idx < NV) begin
        check({tag, "_result"}, res, vexp[idx]);
        check({tag, "_latency"}, t - idx, stages);
      end
      idx++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_v;
    int idx1, idx4, idx32;

    // Reset state
    @(negedge clock);
    check("rst_out_valid", out_valid8, 0);
    check("rst_in_ready", in_ready8, 1);
    check("rst_sum", sum8, 0);
    check("rst_carry_out", carry_out8, 0);
    check("rst_overflow", overflow8, 0);
    check("rst_s4_out_valid", out_valid_s4, 0);
    check("rst_s32_in_ready", in_ready_s32, 1);
    reset = 1'b0;

    // Directed arithmetic on the 8-bit instance
    do_op8("ff_plus_01", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op8("7f_plus_01", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op8("05_minus_07", 8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    do_op8("80_minus_01", 8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1);
    do_op8("0f_plus_cin", 8'h0F, 8'h00, 1'b1, 1'b0, 8'h10, 1'b0, 1'b0);

    // Back-to-back beats with a 3-edge output stall
    exp_q = {8'h11, 8'h22, 8'h33};
    @(negedge clock);
    augend8 = 8'h10; addend8 = 8'h01; carry_in8 = 1'b0; subtract8 = 1'b0; in_valid8 = 1'b1;
    @(negedge clock);
    augend8 = 8'h20; addend8 = 8'h02;
    @(negedge clock);
    check("stall_first_valid", out_valid8, 1);
    check("stall_first_sum", sum8, 8'h11);
    augend8 = 8'h30; addend8 = 8'h03;
    out_ready8 = 1'b0;
    #1 check("stall_in_ready_low", in_ready8, 0);
    repeat (2) begin
      @(negedge clock);
      check("stall_hold_valid", out_valid8, 1);
      check("stall_hold_sum", sum8, 8'h11);
      check("stall_hold_in_ready", in_ready8, 0);
    end
    @(negedge clock);
    out_ready8 = 1'b1;
    #1 check("stall_release_in_ready", in_ready8, 1);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      if (i > 0) @(negedge clock);
      if (i == 1) in_valid8 = 1'b0;
      if (out_valid8) begin
        exp_v = exp_q.pop_front();
        check("stall_drain_sum", sum8, exp_v);
      end
    end
    check("stall_queue_empty", exp_q.size(), 0);
    @(negedge clock);
    check("stall_no_duplicate", out_valid8, 0);

    // Shared 32-bit stream through 1, 4 and 32 stage instances
    idx1 = 0; idx4 = 0; idx32 = 0;
    for (int t = 0; t < NV + 40; t++) begin
      @(negedge clock);
      mon32("s1", out_valid_s1, {co_s1, ov_s1, sum_s1}, t, 1, idx1);
      mon32("s4", out_valid_s4, {co_s4, ov_s4, sum_s4}, t, 4, idx4);
      mon32("s32", out_valid_s32, {co_s32, ov_s32, sum_s32}, t, 32, idx32);
      if (t < NV) begin
        augend32 = va[t]; addend32 = vb[t]; carry_in32 = vci[t]; subtract32 = vsub[t];
        in_valid32 = 1'b1;
      end else begin
        in_valid32 = 1'b0;
      end
    end
    check("s1_count", idx1, NV);
    check("s4_count", idx4, NV);
    check("s32_count", idx32, NV);

    // Asynchronous reset with two beats in flight
    @(negedge clock);
    augend8 = 8'h41; addend8 = 8'h01; carry_in8 = 1'b0; subtract8 = 1'b0; in_valid8 = 1'b1;
    @(negedge clock);
    augend8 = 8'h50; addend8 = 8'h05;
    @(posedge clock);
    #2 in_valid8 = 1'b0;
    check("midrst_pre_valid", out_valid8, 1);
    reset = 1'b1;
    #1;
    check("midrst_out_valid", out_valid8, 0);
    check("midrst_sum", sum8, 0);
    check("midrst_in_ready", in_ready8, 1);
    @(negedge clock);
    reset = 1'b0;
    repeat (4) begin
      @(negedge clock);
      check("midrst_no_stale", out_valid8, 0);
      check("midrst_ready_after", in_ready8, 1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
